// File: rtl/div16_seq_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and counter sizing.
package div16_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Iteration counter width for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div16_seq_sub16.sv
// Combinational WIDTH-bit subtractor with borrow out, used for the trial subtraction.
module sub16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    // Extend by one bit so the MSB of the result is the borrow.
    assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
module div16_seq
    import div16_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e           r_state;
    state_e           w_state_next;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_next;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] w_dvs_next;
    logic             r_dbz;
    logic             w_dbz_next;

    // {rem, quo} shifted left by one; bit WIDTH is the bit shifted out of rem.
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow_lo;
    logic             w_borrow;

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};

    sub16 #(
        .WIDTH (WIDTH)
    ) u_sub (
        .i_a      (w_rem_sh[WIDTH-1:0]),
        .i_b      (r_dvs),
        .o_diff   (w_diff),
        .o_borrow (w_borrow_lo)
    );

    // A set top bit of the shifted remainder cancels the low-part borrow.
    assign w_borrow = w_borrow_lo & ~w_rem_sh[WIDTH];

    // Next-state, operand capture and one restoring step per RUN cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_quo_next   = r_quo;
        w_rem_next   = r_rem;
        w_dvs_next   = r_dvs;
        w_dbz_next   = r_dbz;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_dvs_next = divisor;
                    w_cnt_next = '0;
                    if (divisor == '0) begin
                        w_dbz_next   = 1'b1;
                        w_quo_next   = {WIDTH{1'b1}};
                        w_rem_next   = dividend;
                        w_state_next = StDone;
                    end else begin
                        w_dbz_next   = 1'b0;
                        w_quo_next   = dividend;
                        w_rem_next   = '0;
                        w_state_next = StRun;
                    end
                end
            end
            StRun: begin
                if (w_borrow) begin
                    w_rem_next = w_rem_sh[WIDTH-1:0];
                    w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
                end else begin
                    w_rem_next = w_diff;
                    w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
                end
                w_cnt_next = r_cnt + CntW'(1);
                if (r_cnt == CntW'(WIDTH - 1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_quo   <= w_quo_next;
            r_rem   <= w_rem_next;
            r_dvs   <= w_dvs_next;
            r_dbz   <= w_dbz_next;
        end
    end

    assign busy        = (r_state == StRun);
    assign done        = (r_state == StDone);
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
